// File: rtl/median_filter.sv
// Sliding-window median filter: rank-selects the median of the newest N samples.
// Optional MEDIAN_FILTER_PIPE_EN adds a register after the comparison stage.
module median_filter #(
  parameter int R_WIDTH = 8,
  parameter int N       = 5
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [R_WIDTH-1:0] X,
  output logic [R_WIDTH-1:0] Y
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] MID = CW'((N - 1) / 2);

  if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
    $error("median_filter: N must be odd and >= 3");
  end

  logic [R_WIDTH-1:0] r_win [N];
  logic [R_WIDTH-1:0] r_y;

  logic [R_WIDTH-1:0] w_cand [N];
  logic [CW-1:0]      w_rank [N];
  logic [R_WIDTH-1:0] w_sel_cand [N];
  logic [CW-1:0]      w_sel_rank [N];
  logic [R_WIDTH-1:0] w_med;

  // Updated window: incoming sample plus the N-1 newest stored samples
  always_comb begin
    w_cand[0] = X;
    for (int i = 1; i < N; i++) begin
      w_cand[i] = r_win[i-1];
    end
  end

  // Rank of each candidate; equal values ordered by window index
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_rank[i] = '0;
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          if ((w_cand[j] < w_cand[i]) ||
              ((w_cand[j] == w_cand[i]) && (j < i))) begin
            w_rank[i] = w_rank[i] + CW'(1);
          end
        end
      end
    end
  end

`ifdef MEDIAN_FILTER_PIPE_EN
  logic [R_WIDTH-1:0] r_p_cand [N];
  logic [CW-1:0]      r_p_rank [N];

  // Hold comparison results for one cycle before selection
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < N; i++) begin
        r_p_cand[i] <= '0;
        r_p_rank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_p_cand[i] <= w_cand[i];
        r_p_rank[i] <= w_rank[i];
      end
    end
  end

  // Selection reads from the pipeline register
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_sel_cand[i] = r_p_cand[i];
      w_sel_rank[i] = r_p_rank[i];
    end
  end
`else
  // Selection reads the comparison results directly
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_sel_cand[i] = w_cand[i];
      w_sel_rank[i] = w_rank[i];
    end
  end
`endif

  // Exactly one rank matches the middle; OR-reduce the selected value
  always_comb begin
    w_med = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel_rank[i] == MID) begin
        w_med = w_med | w_sel_cand[i];
      end
    end
  end

  // Shift the window and register the median
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < N; i++) begin
        r_win[i] <= '0;
      end
      r_y <= '0;
    end else begin
      r_win[0] <= X;
      for (int i = 1; i < N; i++) begin
        r_win[i] <= r_win[i-1];
      end
      r_y <= w_med;
    end
  end

  assign Y = r_y;

endmodule

// File: tb/tb_median_filter.sv
// Scoreboard bench for median_filter: sorted-queue reference model,
// directed scenarios plus randomized streams with occasional resets.
module tb_median_filter;

  localparam int W = 8;
  localparam int N = 5;

  logic         clk;
  logic         srst;
  logic [W-1:0] X;
  logic [W-1:0] Y;

  typedef struct {
    logic [W-1:0] y;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   win[$];
  int   checks;
  int   failures;
  int   pipe_e;
  int   y_e;
  bit   done;

  median_filter #(.R_WIDTH(W), .N(N)) dut (
    .clk (clk),
    .srst(srst),
    .X   (X),
    .Y   (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_median();
    int s[$];
    s = win;
    s.sort();
    return s[(N - 1) / 2];
  endfunction

  // Drive one sample and queue the value Y must show after this edge
  task automatic step(input int x, input bit r, input string nm);
    exp_t e;
    @(negedge clk);
    X    = W'(x);
    srst = r;
    if (r) begin
      win.delete();
      for (int i = 0; i < N; i++) win.push_back(0);
      pipe_e = 0;
      y_e    = 0;
    end else begin
      win.push_front(x);
      void'(win.pop_back());
`ifdef MEDIAN_FILTER_PIPE_EN
      y_e    = pipe_e;
      pipe_e = ref_median();
`else
      y_e    = ref_median();
`endif
    end
    e.y    = W'(y_e);
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare Y after every edge that has an expectation queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Y !== e.y) begin
          failures++;
          $display("FAIL %s: Y=%0d expected %0d at %0t",
                   e.name, Y, e.y, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: done=%0d required 1", done);
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    checks   = 0;
    failures = 0;
    done     = 0;
    pipe_e   = 0;
    y_e      = 0;
    srst     = 1'b1;
    X        = '0;

    // Startup
    step(0, 1, "reset0");
    step(0, 1, "reset1");
    step(255, 0, "startup");
    // Full window then sliding with duplicates
    step(0, 1, "reset2");
    step(255, 0, "full1");
    step(200, 0, "full2");
    step(10,  0, "full3");
    step(166, 0, "full4");
    step(131, 0, "full5");
    step(59,  0, "slide1");
    step(4,   0, "slide2");
    step(59,  0, "slide3");
    // Fill behaviour with a constant
    step(0, 1, "reset3");
    for (int i = 0; i < 5; i++) step(77, 0, "fill");
    // Mid-stream reset with a window full of 200
    for (int i = 0; i < 6; i++) step(200, 0, "pre_rst");
    step(200, 1, "mid_rst");
    for (int i = 0; i < 4; i++) step(200, 0, "post_rst");
    // Extremes: alternating and random 0/255 patterns
    for (int i = 0; i < 12; i++) step((i % 2) ? 255 : 0, 0, "alt");
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 1) ? 255 : 0, 0, "extreme");
    end
    // Random wide and narrow ranges, occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        step(int'($urandom_range(0, 255)), 1, "rnd_rst");
      end else if (i < 200) begin
        step(int'($urandom_range(0, 255)), 0, "rnd_wide");
      end else begin
        v = int'($urandom_range(0, 3));
        step(v * 85, 0, "rnd_dup");
      end
    end

    @(posedge clk);
    #2;
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
